fb_gray_code_gen: RTL and testbench

Upstream feeder of the feedback gray selector stage. It generates the free-running gray-code timebase whose bit edges time the selector, and it holds the up/down feedback code whose upper bits the selector serialises. It replaces the separate cclk divider, gray counter and up/down binary counter with one synchronous block, so every output comes from a register on clk_ext.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_sat_updown.sv | 66 ++++++
 rtl/fb_gray_code_gen.sv | 104 ++++++++++
 tb/tb_fb_gray_code_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared defaults and helpers for the feedback gray-code generator.
//   GRAY_W     - default gray timebase width
//   CODE_W     - default feedback code width
//   SEL_N      - default number of bits presented to the selector
//   CDIV       - default clk_ext cycles per code-update tick
//   CODE_MAX   - all-ones feedback code at the default width
//   bin2gray() - binary to reflected gray conversion, up to BIN2GRAY_W bits
package fb_pkg;

    localparam int unsigned GRAY_W     = 19;
    localparam int unsigned CODE_W     = 16;
    localparam int unsigned SEL_N      = 10;
    localparam int unsigned CDIV       = 8;
    localparam int unsigned BIN2GRAY_W = 32;

    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

    // Reflected binary code; callers zero-extend narrower values and truncate the result.
    function automatic logic [BIN2GRAY_W-1:0] bin2gray(input logic [BIN2GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fb_sat_updown.sv
// fb_sat_updown: saturating up/down counter with synchronous load.
//   clk      in  1  rising-edge clock
//   rst      in  1  synchronous reset, active-high, to RST_VAL
//   load     in  1  load strobe, beats tick/en
//   load_val in  W  value taken when load=1
//   en       in  1  qualifies tick
//   tick     in  1  update strobe; one step per cycle it is high with en
//   u_d      in  1  1 = up (saturate at all ones), 0 = down (saturate at 0)
//   code     out W  counter value
//   at_max   out 1  code is all ones, registered alongside code
//   at_min   out 1  code is zero, registered alongside code
module fb_sat_updown
    import fb_pkg::*;
#(
    parameter int unsigned     W       = CODE_W,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         tick,
    input  logic         u_d,
    output logic [W-1:0] code,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] MIN_VAL = '0;

    logic [W-1:0] code_d;

    // Next code: load first, then a saturating step on an enabled tick, else hold.
    always_comb begin
        code_d = code;
        if (load) begin
            code_d = load_val;
        end else if (tick && en) begin
            if (u_d) begin
                if (code != MAX_VAL) begin
                    code_d = code + W'(1);
                end
            end else begin
                if (code != MIN_VAL) begin
                    code_d = code - W'(1);
                end
            end
        end
    end

    // Flags are computed from the next value so they land on the same edge as code.
    always_ff @(posedge clk) begin
        if (rst) begin
            code   <= RST_VAL;
            at_max <= (RST_VAL == MAX_VAL);
            at_min <= (RST_VAL == MIN_VAL);
        end else begin
            code   <= code_d;
            at_max <= (code_d == MAX_VAL);
            at_min <= (code_d == MIN_VAL);
        end
    end

endmodule

// File: rtl/fb_gray_code_gen.sv
// fb_gray_code_gen: gray-code timebase, update-tick divider and saturating
// feedback code feeding the feedback gray selector. All outputs are registers
// on clk_ext (gray_clk and fb_bits are fixed bit selects of registers).
//   clk_ext  in  1       core clock
//   rst      in  1       synchronous reset, active-high, highest priority
//   en       in  1       enables code updates on tick
//   u_d      in  1       1 = count up, 0 = count down
//   load     in  1       synchronous load strobe
//   load_val in  CODE_W  value loaded when load=1
//   gray_clk out SEL_N   gray[SEL_N:1]
//   fb_bits  out SEL_N   fb_bits[i] = code[CODE_W-1-i]
//   code     out CODE_W  current feedback code
//   tick     out 1       one-cycle strobe, high on the cycle an update becomes visible
//   at_max   out 1       code is all ones
//   at_min   out 1       code is zero
module fb_gray_code_gen
#(
    parameter int unsigned        GRAY_W   = fb_pkg::GRAY_W,
    parameter int unsigned        CODE_W   = fb_pkg::CODE_W,
    parameter int unsigned        SEL_N    = fb_pkg::SEL_N,
    parameter int unsigned        CDIV     = fb_pkg::CDIV,
    parameter logic [CODE_W-1:0]  RST_CODE = '0
) (
    input  logic              clk_ext,
    input  logic              rst,
    input  logic              en,
    input  logic              u_d,
    input  logic              load,
    input  logic [CODE_W-1:0] load_val,
    output logic [SEL_N-1:0]  gray_clk,
    output logic [SEL_N-1:0]  fb_bits,
    output logic [CODE_W-1:0] code,
    output logic              tick,
    output logic              at_max,
    output logic              at_min
);

    import fb_pkg::bin2gray;
    import fb_pkg::BIN2GRAY_W;

    localparam int unsigned      DIV_W    = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CDIV - 1);

    logic [GRAY_W-1:0] tb_cnt;
    logic [GRAY_W-1:0] tb_next;
    logic [GRAY_W-1:0] gray;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick_c;
    logic              unused_gray_bits;

    assign tb_next = tb_cnt + GRAY_W'(1);
    assign tick_c  = (div_cnt == DIV_LAST);

    // Timebase: gray is encoded from the incremented count so it never lags tb_cnt.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            tb_cnt <= '0;
            gray   <= '0;
        end else begin
            tb_cnt <= tb_next;
            gray   <= GRAY_W'(bin2gray(BIN2GRAY_W'(tb_next)));
        end
    end

    // Divider: the update happens on the edge leaving div_cnt==CDIV-1, and the
    // registered tick marks the cycle in which the updated code is visible.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            tick    <= tick_c;
        end
    end

    // Feedback code; driven by the pre-register tick so code and tick rise together.
    fb_sat_updown #(
        .W       (CODE_W),
        .RST_VAL (RST_CODE)
    ) u_code (
        .clk      (clk_ext),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .tick     (tick_c),
        .u_d      (u_d),
        .code     (code),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    assign gray_clk = gray[SEL_N:1];

    // Selector data inputs take the code MSB-first.
    for (genvar i = 0; i < int'(SEL_N); i++) begin : g_fb_bits
        assign fb_bits[i] = code[CODE_W-1-i];
    end

    // Gray LSB and upper bits only exist to complete the timebase sequence.
    assign unused_gray_bits = ^{gray[GRAY_W-1:SEL_N+1], gray[0]};

endmodule

// File: tb/tb_fb_gray_code_gen.sv
// tb_fb_gray_code_gen: scoreboard bench for fb_gray_code_gen. Each clock step
// pushes the expected post-edge outputs from a behavioural model; scenario
// tasks pop and compare them and add scenario-specific checks.
module tb_fb_gray_code_gen;

    localparam int unsigned       GRAY_W   = 19;
    localparam int unsigned       CODE_W   = 16;
    localparam int unsigned       SEL_N    = 10;
    localparam int unsigned       CDIV     = 8;
    localparam logic [CODE_W-1:0] RST_CODE = '0;

    logic              clk_ext = 1'b0;
    logic              rst;
    logic              en;
    logic              u_d;
    logic              load;
    logic [CODE_W-1:0] load_val;
    logic [SEL_N-1:0]  gray_clk;
    logic [SEL_N-1:0]  fb_bits;
    logic [CODE_W-1:0] code;
    logic              tick;
    logic              at_max;
    logic              at_min;

    typedef struct packed {
        logic [SEL_N-1:0]  gclk;
        logic              tick;
        logic [CODE_W-1:0] code;
        logic              at_max;
        logic              at_min;
        logic [SEL_N-1:0]  fb;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    int unsigned       m_tb;
    int unsigned       m_div;
    logic [CODE_W-1:0] m_code;
    int unsigned       cyc;

    always #5 clk_ext = ~clk_ext;

    fb_gray_code_gen #(
        .GRAY_W   (GRAY_W),
        .CODE_W   (CODE_W),
        .SEL_N    (SEL_N),
        .CDIV     (CDIV),
        .RST_CODE (RST_CODE)
    ) dut (
        .clk_ext  (clk_ext),
        .rst      (rst),
        .en       (en),
        .u_d      (u_d),
        .load     (load),
        .load_val (load_val),
        .gray_clk (gray_clk),
        .fb_bits  (fb_bits),
        .code     (code),
        .tick     (tick),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    function automatic obs_t sample();
        obs_t o;
        o = {gray_clk, tick, code, at_max, at_min, fb_bits};
        return o;
    endfunction

    // Advance the model by one edge from the current inputs, push the expectation, clock the DUT.
    task automatic step();
        obs_t              e;
        logic [GRAY_W-1:0] g;
        logic              tk;
        if (rst) begin
            m_tb   = 0;
            m_div  = 0;
            tk     = 1'b0;
            m_code = RST_CODE;
            cyc    = 0;
        end else begin
            m_tb  = (m_tb + 1) & ((32'd1 << GRAY_W) - 1);
            tk    = (m_div == CDIV - 1);
            m_div = tk ? 0 : m_div + 1;
            if (load) begin
                m_code = load_val;
            end else if (tk && en) begin
                if (u_d && m_code != 16'hFFFF) m_code = m_code + 16'd1;
                else if (!u_d && m_code != 16'h0000) m_code = m_code - 16'd1;
            end
            cyc++;
        end
        g        = GRAY_W'(m_tb ^ (m_tb >> 1));
        e.gclk   = g[SEL_N:1];
        e.tick   = tk;
        e.code   = m_code;
        e.at_max = (m_code == 16'hFFFF);
        e.at_min = (m_code == 16'h0000);
        for (int i = 0; i < int'(SEL_N); i++) e.fb[i] = m_code[CODE_W-1-i];
        sb.push_back(e);
        @(posedge clk_ext);
        #1;
    endtask

    task automatic do_reset();
        obs_t e;
        rst  = 1'b1;
        step();
        e    = sb.pop_front();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        en = 1'b0; u_d = 1'b0; load = 1'b0; load_val = '0;
        rst = 1'b1;
        step();
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL reset_sb got=%h exp=%h", o, e);
        end
        checks++;
        if (gray_clk !== 10'h000 || tick !== 1'b0 || code !== 16'h0000 ||
            at_min !== 1'b1 || at_max !== 1'b0 || fb_bits !== 10'h000) begin
            errors++;
            $display("FAIL reset_vals got gclk=%h tick=%b code=%h max=%b min=%b fb=%h exp all zero, min=1",
                     gray_clk, tick, code, at_max, at_min, fb_bits);
        end
        rst = 1'b0;
    endtask

    task automatic test_timebase();
        obs_t             e, o;
        logic [SEL_N-1:0] prev;
        int               last0, last9, n9;
        do_reset();
        prev = gray_clk; last0 = -1; last9 = -1; n9 = 0;
        for (int n = 1; n <= 5200; n++) begin
            step();
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                if (errors <= 20) $display("FAIL timebase_sb cyc=%0d got=%h exp=%h", n, o, e);
            end
            checks++;
            if ($countones(gray_clk ^ prev) > 1) begin
                errors++;
                if (errors <= 20) $display("FAIL gray_one_bit cyc=%0d changed=%0d exp<=1", n, $countones(gray_clk ^ prev));
            end
            if (gray_clk[0] && !prev[0]) begin
                if (last0 >= 0) begin
                    checks++;
                    if (n - last0 != 8) begin
                        errors++;
                        if (errors <= 20) $display("FAIL gclk0_period got=%0d exp=8", n - last0);
                    end
                end
                last0 = n;
            end
            if (gray_clk[9] && !prev[9]) begin
                if (last9 >= 0) begin
                    checks++;
                    if (n - last9 != 4096) begin
                        errors++; $display("FAIL gclk9_period got=%0d exp=4096", n - last9);
                    end
                end
                last9 = n; n9++;
            end
            prev = gray_clk;
        end
        checks++;
        if (n9 != 2) begin
            errors++; $display("FAIL gclk9_rises got=%0d exp=2", n9);
        end
        checks++;
        if (code !== 16'h0000 || at_min !== 1'b1) begin
            errors++; $display("FAIL idle_code got=%h min=%b exp=0000 min=1", code, at_min);
        end
    endtask

    task automatic test_count_up();
        obs_t e, o;
        logic exp_tick;
        int   nticks;
        do_reset();
        en = 1'b1; u_d = 1'b1; nticks = 0;
        for (int n = 1; n <= 80; n++) begin
            step();
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL count_up_sb cyc=%0d got=%h exp=%h", n, o, e);
            end
            exp_tick = ((n % CDIV) == 0);
            checks++;
            if (tick !== exp_tick) begin
                errors++; $display("FAIL tick_phase cyc=%0d got=%b exp=%b", n, tick, exp_tick);
            end
            if (tick === 1'b1) nticks++;
        end
        checks++;
        if (code !== 16'd10 || fb_bits !== 10'h000 || nticks != 10) begin
            errors++; $display("FAIL count_up_end got code=%h fb=%h ticks=%0d exp 000a 000 10", code, fb_bits, nticks);
        end
        en = 1'b0;
    endtask

    task automatic test_sat(input logic up);
        obs_t e, o;
        load = 1'b1; load_val = up ? 16'hFFFE : 16'h0001; en = 1'b0; u_d = up;
        step();
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL sat_load up=%b got=%h exp=%h", up, o, e);
        end
        load = 1'b0; en = 1'b1;
        for (int n = 0; n < 3 * int'(CDIV); n++) begin
            step();
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL sat_run up=%b n=%0d got=%h exp=%h", up, n, o, e);
            end
        end
        checks++;
        if (up) begin
            if (code !== 16'hFFFF || at_max !== 1'b1 || at_min !== 1'b0 || fb_bits !== 10'h3FF) begin
                errors++; $display("FAIL sat_max got code=%h max=%b fb=%h exp ffff 1 3ff", code, at_max, fb_bits);
            end
        end else begin
            if (code !== 16'h0000 || at_min !== 1'b1 || at_max !== 1'b0) begin
                errors++; $display("FAIL sat_min got code=%h min=%b exp 0000 1", code, at_min);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        obs_t e, o;
        int   guard;
        en = 1'b1; u_d = 1'b1; load = 1'b0; guard = 0;
        while (m_div != CDIV - 1 && guard < 2 * int'(CDIV)) begin
            step();
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL load_pri_pre got=%h exp=%h", o, e);
            end
            guard++;
        end
        load = 1'b1; load_val = 16'h1234;
        step();
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL load_pri_sb got=%h exp=%h", o, e);
        end
        checks++;
        if (code !== 16'h1234 || tick !== 1'b1) begin
            errors++; $display("FAIL load_pri got code=%h tick=%b exp 1234 1", code, tick);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_mid_reset();
        obs_t e, o;
        int   n;
        load = 1'b1; load_val = 16'h4000; en = 1'b1; u_d = 1'b1;
        step();
        e = sb.pop_front();
        load = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            e = sb.pop_front();
        end
        checks++;
        if (code !== 16'h4000) begin
            errors++; $display("FAIL mid_pre got=%h exp=4000", code);
        end
        en = 1'b1;
        rst = 1'b1;
        step();
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++; $display("FAIL mid_rst_sb got=%h exp=%h", o, e);
        end
        checks++;
        if (code !== RST_CODE || gray_clk !== 10'h000 || tick !== 1'b0) begin
            errors++; $display("FAIL mid_rst got code=%h gclk=%h tick=%b exp 0000 000 0", code, gray_clk, tick);
        end
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL mid_post_sb n=%0d got=%h exp=%h", n, o, e);
            end
        end while (tick !== 1'b1 && n < 4 * int'(CDIV));
        checks++;
        if (n != int'(CDIV)) begin
            errors++; $display("FAIL mid_tick_delay got=%0d exp=%0d", n, CDIV);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timebase();
        test_count_up();
        test_sat(1'b1);
        test_sat(1'b0);
        test_load_priority();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
